// File: rtl/bram_pkg.sv
// bram_pkg: state encoding and byte-lane helper shared by the dual-port byte-enable RAM
package bram_pkg;
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;
  function automatic int nbytes(input int data_width, input int byte_size);
    return data_width / byte_size;
  endfunction
endpackage

// File: rtl/bram_out_pipe.sv
// bram_out_pipe: per-port read-data register, optional second stage, valid pipeline and hold
module bram_out_pipe #(
  parameter int DW = 64,
  parameter int PIPELINED = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);
  logic          v1_q, v1_d, v2_q, v2_d;
  logic [DW-1:0] d1_q, d1_d, d2_q, d2_d;
  always_comb begin
    v1_d = rst_n & in_valid;
    d1_d = !rst_n ? '0 : in_valid ? in_data : d1_q;
    v2_d = rst_n & v1_q;
    d2_d = !rst_n ? '0 : v1_q ? d1_q : d2_q;
  end
  always_ff @(posedge clk) begin
    v1_q <= v1_d;
    d1_q <= d1_d;
    v2_q <= v2_d;
    d2_q <= d2_d;
  end
  assign out_valid = (PIPELINED != 0) ? v2_q : v1_q;
  assign out_data  = (PIPELINED != 0) ? d2_q : d1_q;
endmodule

// File: rtl/bram2_be_clr.sv
// bram2_be_clr: true dual-port RAM with byte enables, write-first read-modify-write and zero-fill after reset
module bram2_be_clr
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int BYTE_SIZE = 8,
  parameter int MEMSIZE = 1024,
  parameter int PIPELINED = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NBYTES = nbytes(DATA_WIDTH, BYTE_SIZE)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  output logic                  READY,
  input  logic                  ENA,
  input  logic [NBYTES-1:0]     WEA,
  input  logic [ADDR_WIDTH-1:0] ADDRA,
  input  logic [DATA_WIDTH-1:0] DIA,
  output logic [DATA_WIDTH-1:0] DOA,
  output logic                  DOA_VALID,
  input  logic                  ENB,
  input  logic [NBYTES-1:0]     WEB,
  input  logic [ADDR_WIDTH-1:0] ADDRB,
  input  logic [DATA_WIDTH-1:0] DIB,
  output logic [DATA_WIDTH-1:0] DOB,
  output logic                  DOB_VALID
);
  localparam int IW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam logic [ADDR_WIDTH:0] MS = (ADDR_WIDTH + 1)'(MEMSIZE);
  if (DATA_WIDTH % BYTE_SIZE != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of BYTE_SIZE");
  end
  if (MEMSIZE > (1 << ADDR_WIDTH)) begin : g_bad_size
    $error("MEMSIZE must not exceed 2**ADDR_WIDTH");
  end
  logic [DATA_WIDTH-1:0] mem [MEMSIZE];
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_q, clr_d;
  logic                  ready_q, ready_d;
  logic                  acc_a, acc_b, in_a, in_b, same, last;
  logic [DATA_WIDTH-1:0] old_a, old_b, new_a, new_b, dout_a, dout_b;
  always_comb begin
    last    = {1'b0, clr_q} == MS - 1'b1;
    state_d = !RST_N ? (CLEAR_ON_RESET != 0 ? CLEAR : RUN) : (state_q == CLEAR && last) ? RUN : state_q;
    clr_d   = !RST_N ? '0 : (state_q == CLEAR) ? clr_q + 1'b1 : clr_q;
    ready_d = RST_N && state_d == RUN;
  end
  always_ff @(posedge CLK) begin
    state_q <= state_d;
    clr_q   <= clr_d;
    ready_q <= ready_d;
  end
  assign READY = ready_q;
  // A colliding write merges both ports' lanes, A winning, so both ports see one word
  always_comb begin
    acc_a = ENA & ready_q & RST_N;
    acc_b = ENB & ready_q & RST_N;
    in_a  = {1'b0, ADDRA} < MS;
    in_b  = {1'b0, ADDRB} < MS;
    same  = acc_a & acc_b & in_a & in_b & (ADDRA == ADDRB);
    old_a = in_a ? mem[ADDRA[IW-1:0]] : '0;
    old_b = in_b ? mem[ADDRB[IW-1:0]] : '0;
    new_a = '0;
    new_b = '0;
    for (int i = 0; i < NBYTES; i++) begin
      new_a[i*BYTE_SIZE +: BYTE_SIZE] = WEA[i] ? DIA[i*BYTE_SIZE +: BYTE_SIZE]
        : (same && WEB[i]) ? DIB[i*BYTE_SIZE +: BYTE_SIZE] : old_a[i*BYTE_SIZE +: BYTE_SIZE];
      new_b[i*BYTE_SIZE +: BYTE_SIZE] = same ? new_a[i*BYTE_SIZE +: BYTE_SIZE]
        : WEB[i] ? DIB[i*BYTE_SIZE +: BYTE_SIZE] : old_b[i*BYTE_SIZE +: BYTE_SIZE];
    end
    dout_a = in_a ? new_a : '0;
    dout_b = in_b ? new_b : '0;
  end
  always_ff @(posedge CLK) begin
    if (RST_N && state_q == CLEAR) mem[clr_q[IW-1:0]] <= '0;
    if (acc_a && in_a) mem[ADDRA[IW-1:0]] <= new_a;
    if (acc_b && in_b && !same) mem[ADDRB[IW-1:0]] <= new_b;
  end
  bram_out_pipe #(.DW(DATA_WIDTH), .PIPELINED(PIPELINED)) u_pipe_a (
    .clk(CLK), .rst_n(RST_N), .in_valid(acc_a), .in_data(dout_a), .out_valid(DOA_VALID), .out_data(DOA)
  );
  bram_out_pipe #(.DW(DATA_WIDTH), .PIPELINED(PIPELINED)) u_pipe_b (
    .clk(CLK), .rst_n(RST_N), .in_valid(acc_b), .in_data(dout_b), .out_valid(DOB_VALID), .out_data(DOB)
  );
endmodule

// File: tb/tb_bram2_be_clr.sv
// tb_bram2_be_clr: directed checks of a clearing 1-cycle instance and a non-clearing 2-cycle instance
module tb_bram2_be_clr;
  localparam int AW = 6;
  localparam int DW = 64;
  localparam int NB = 8;
  localparam int MS = 16;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en0a, en0b, en1a, en1b;
  logic [NB-1:0] wea, web;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dia, dib;
  logic          rdy0, rdy1, va0, vb0, va1, vb1;
  logic [DW-1:0] doa0, dob0, doa1, dob1;
  logic [DW-1:0] exp0 [MS];
  int            vec = 0;
  int            miss = 0;
  int            cnt, na, nb;
  logic          seen, ev;

  bram2_be_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SIZE(8), .MEMSIZE(MS), .PIPELINED(0), .CLEAR_ON_RESET(1)) dut0 (
    .CLK(clk), .RST_N(rst_n), .READY(rdy0),
    .ENA(en0a), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa0), .DOA_VALID(va0),
    .ENB(en0b), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob0), .DOB_VALID(vb0)
  );
  bram2_be_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SIZE(8), .MEMSIZE(MS), .PIPELINED(1), .CLEAR_ON_RESET(0)) dut1 (
    .CLK(clk), .RST_N(rst_n), .READY(rdy1),
    .ENA(en1a), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa1), .DOA_VALID(va1),
    .ENB(en1b), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob1), .DOB_VALID(vb1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vec++;
    assert (obs === exp_v) else begin
      miss++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic drv(input logic [3:0] en, input int aa, input logic [7:0] wa, input logic [63:0] da,
                     input int ab, input logic [7:0] wb, input logic [63:0] db);
    {en0a, en0b, en1a, en1b} = en;
    addra = AW'(aa);
    wea   = wa;
    dia   = da;
    addrb = AW'(ab);
    web   = wb;
    dib   = db;
  endtask

  function automatic logic [63:0] pat(input int a);
    logic [7:0] b;
    b = 8'(a + 1);
    return {8{b}};
  endfunction

  initial begin
    drv(4'b0000, 0, 8'h00, 64'h0, 0, 8'h00, 64'h0);
    tick();
    tick();
    chk("rst_ready0", rdy0, 0);
    chk("rst_ready1", rdy1, 0);
    chk("rst_doa0", doa0, 0);
    chk("rst_va0", va0, 0);
    chk("rst_vb1", vb1, 0);
    rst_n = 1'b1;
    drv(4'b1000, 0, 8'hFF, {64{1'b1}}, 0, 8'h00, 64'h0);
    cnt = 0;
    seen = 1'b0;
    while (!rdy0 && cnt < 40) begin
      tick();
      cnt++;
      seen |= va0;
      if (cnt == 1) chk("ready1_first_cycle", rdy1, 1);
    end
    drv(4'b0000, 0, 8'h00, 64'h0, 0, 8'h00, 64'h0);
    chk("clear_cycles", cnt, 16);
    chk("clear_ignores_en", seen, 0);
    for (int a = 0; a < MS; a++) begin
      drv(4'b1000, a, 8'h00, 64'h0, 0, 8'h00, 64'h0);
      tick();
      chk($sformatf("clr_valid_%0d", a), va0, 1);
      chk($sformatf("clr_data_%0d", a), doa0, 0);
    end
    drv(4'b1000, 5, 8'hFF, 64'h1122334455667788, 0, 8'h00, 64'h0);
    tick();
    chk("wr_full", doa0, 64'h1122334455667788);
    drv(4'b1000, 5, 8'h0F, {8{8'hAA}}, 0, 8'h00, 64'h0);
    tick();
    chk("wr_low_lanes", doa0, 64'h11223344AAAAAAAA);
    chk("wr_low_valid", va0, 1);
    drv(4'b0100, 0, 8'h00, 64'h0, 5, 8'h00, 64'h0);
    tick();
    chk("b_sees_a_write", dob0, 64'h11223344AAAAAAAA);
    chk("a_idle_valid", va0, 0);
    chk("a_idle_hold", doa0, 64'h11223344AAAAAAAA);
    drv(4'b1100, 3, 8'hF0, {8{8'hBB}}, 3, 8'hFF, {8{8'hCC}});
    tick();
    chk("collide_a", doa0, 64'hBBBBBBBBCCCCCCCC);
    chk("collide_b", dob0, 64'hBBBBBBBBCCCCCCCC);
    drv(4'b1100, 3, 8'h00, 64'h0, 3, 8'h01, {8{8'hEE}});
    tick();
    chk("collide_rd_a", doa0, 64'hBBBBBBBBCCCCCCEE);
    chk("collide_rd_b", dob0, 64'hBBBBBBBBCCCCCCEE);
    drv(4'b1100, 7, 8'hFF, 64'h0102030405060708, 3, 8'h00, 64'h0);
    tick();
    chk("split_a", doa0, 64'h0102030405060708);
    chk("split_b", dob0, 64'hBBBBBBBBCCCCCCEE);
    drv(4'b1100, 16, 8'hFF, {64{1'b1}}, 48, 8'hFF, {64{1'b1}});
    tick();
    chk("oor_a_data", doa0, 0);
    chk("oor_a_valid", va0, 1);
    chk("oor_b_data", dob0, 0);
    chk("oor_b_valid", vb0, 1);
    for (int a = 0; a < MS; a++) exp0[a] = 64'h0;
    exp0[3] = 64'hBBBBBBBBCCCCCCEE;
    exp0[5] = 64'h11223344AAAAAAAA;
    exp0[7] = 64'h0102030405060708;
    for (int a = 0; a < MS; a++) begin
      drv(4'b0100, 0, 8'h00, 64'h0, a, 8'h00, 64'h0);
      tick();
      chk($sformatf("readback_%0d", a), dob0, exp0[a]);
    end
    for (int k = 0; k < 8; k++) begin
      drv(4'b0011, 2 * k, 8'hFF, pat(2 * k), 2 * k + 1, 8'hFF, pat(2 * k + 1));
      tick();
    end
    drv(4'b0000, 0, 8'h00, 64'h0, 0, 8'h00, 64'h0);
    tick();
    tick();
    na = 0;
    nb = 0;
    for (int k = 0; k < 22; k++) begin
      if (k < 20) drv(4'b0011, k % 16, 8'h00, 64'h0, (k + 5) % 16, 8'h00, 64'h0);
      else drv(4'b0000, 0, 8'h00, 64'h0, 0, 8'h00, 64'h0);
      tick();
      na += int'(va1);
      nb += int'(vb1);
      ev = (k >= 1 && k <= 20);
      chk($sformatf("pipe_va_%0d", k), va1, ev);
      chk($sformatf("pipe_vb_%0d", k), vb1, ev);
      if (ev) begin
        chk($sformatf("pipe_doa_%0d", k), doa1, pat((k - 1) % 16));
        chk($sformatf("pipe_dob_%0d", k), dob1, pat((k + 4) % 16));
      end
    end
    chk("pipe_pulses_a", na, 20);
    chk("pipe_pulses_b", nb, 20);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    chk("midclear_ready", rdy0, 0);
    rst_n = 1'b0;
    tick();
    chk("rst2_ready0", rdy0, 0);
    chk("rst2_ready1", rdy1, 0);
    chk("rst2_doa1", doa1, 0);
    chk("rst2_va1", va1, 0);
    rst_n = 1'b1;
    cnt = 0;
    while (!rdy0 && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("reclear_cycles", cnt, 16);
    drv(4'b0010, 9, 8'h00, 64'h0, 0, 8'h00, 64'h0);
    tick();
    drv(4'b0000, 0, 8'h00, 64'h0, 0, 8'h00, 64'h0);
    chk("retain_early_valid", va1, 0);
    tick();
    chk("retain_valid", va1, 1);
    chk("retain_data", doa1, pat(9));
    drv(4'b1000, 5, 8'h00, 64'h0, 0, 8'h00, 64'h0);
    tick();
    drv(4'b0000, 0, 8'h00, 64'h0, 0, 8'h00, 64'h0);
    chk("reclear_data", doa0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
